spike_decoder: RTL
==================

Name: spike_decoder

Overview:
- Output-side counterpart of the neuron array: consumes per-timestep spike vectors from the output-layer neurons and turns the resulting spike trains into a classification result.
- Counts spikes per output neuron over a programmed number of timesteps, then scans sequentially for the neuron with the highest count (argmax).
- Sits between the output neuron layer and the Wishbone-visible result registers.

Parameters:
- NUM_OUTPUTS, 10, number of output neurons / spike lanes
- CNT_WIDTH, 8, width of each per-neuron spike counter and of the timestep count
- IDX_WIDTH, 4, width of the class index; must be >= clog2(NUM_OUTPUTS)

Ports:
- wb_clk_i  input  1  single clock
- wb_rst_i  input  1  reset; synchronous, active-high
- start  input  1  begin a new inference window; sampled every cycle
- num_steps  input  CNT_WIDTH  timesteps per window; latched on accepted start
- spike_valid  input  1  spike_in holds one timestep's spike vector
- spike_in  input  NUM_OUTPUTS  bit i = spike from output neuron i this timestep
- spike_ready  output  1  decoder accepts a vector this cycle
- busy  output  1  window in progress (ACCUM or SCAN)
- done  output  1  result valid; held until next accepted start or reset
- class_out  output  IDX_WIDTH  index of the winning neuron
- class_count  output  CNT_WIDTH  spike count of the winning neuron
- tie  output  1  another neuron has a count equal to class_count

Behaviour:
- Clock and reset: single clock wb_clk_i. Reset wb_rst_i is synchronous and active-high and takes priority over everything. It forces the FSM to IDLE and clears all counters, step count and scan registers.
- Reset values: spike_ready=0, busy=0, done=0, class_out=0, class_count=0, tie=0.
- FSM states: IDLE, ACCUM, SCAN, DONE.
- Start acceptance: start is accepted only in IDLE or DONE and ignored in ACCUM and SCAN. On accept:
  - clear all NUM_OUTPUTS counters and the step counter;
  - latch num_steps;
  - clear done, class_out, class_count and tie;
  - next state is ACCUM, or SCAN directly if num_steps==0.
- ACCUM:
  - spike_ready=1 and busy=1.
  - A vector transfers on a cycle where spike_valid && spike_ready.
  - On transfer, counter[i] increments for each set spike_in[i].
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - The step counter increments on each transfer. When the transfer makes it equal the latched num_steps, the next state is SCAN.
  - spike_valid with spike_ready=0 is ignored; no vector is counted outside ACCUM.
- SCAN:
  - spike_ready=0, busy=1.
  - Lasts exactly NUM_OUTPUTS cycles, examining one index per cycle in ascending order.
  - Index 0 loads best=counter[0], best_idx=0, tie=0.
  - For index i>0:
    - counter[i] > best: best=counter[i], best_idx=i, tie=0.
    - counter[i] == best: tie=1; best and best_idx are unchanged, so the lowest index wins ties.
  - After index NUM_OUTPUTS-1 the next state is DONE.
- Latency: let edge E0 be the edge that accepts the final vector. done, class_out, class_count and tie are valid after edge E0+NUM_OUTPUTS.
- DONE: done=1, busy=0, outputs stable. Counters keep their values until the next accepted start.
- All-zero window (num_steps==0, or no spikes): result is class_out=0, class_count=0, tie=1 (when NUM_OUTPUTS>1).
- Start and spike_valid in the same cycle while in DONE: start is accepted and the vector is ignored, because spike_ready=0 in DONE.
- Reset asserted during ACCUM or SCAN aborts the window: state returns to IDLE, all state clears, and no done is produced.
- Widths: num_steps up to 2^CNT_WIDTH-1; the step counter is CNT_WIDTH wide and compared for equality only.

Test Plan (NUM_OUTPUTS=10, CNT_WIDTH=8):
- Basic argmax: num_steps=4, start; 4 vectors each 10'b00_0000_1001 → done after edge E0+10 with class_out=0, class_count=4, tie=1 (neurons 0 and 3 are tied). Rerun with neuron 3 spiking in all 4 steps and neuron 0 in only 3 → class_out=3, class_count=4, tie=0.
- Backpressure and gaps: num_steps=3; spike_valid toggled 1,0,1,0,1 with neuron 7 set → exactly 3 transfers, class_out=7, class_count=3. Vectors presented during SCAN and DONE are not counted; spike_ready=0 there.
- Saturation: num_steps=255 followed by a second window via start; neuron 9 spikes on every step of 255 → class_count=255, no wrap. The second window with no spikes gives class_count=0, confirming counters clear on start.
- Zero window: num_steps=0, start → SCAN immediately; done after 10 cycles with class_out=0, class_count=0, tie=1; spike_ready never asserts.
- Start ignored while busy: pulse start mid-ACCUM with num_steps=2 pending → window continues with the original latched count; result unaffected.
- Reset mid-operation: assert wb_rst_i during SCAN → next cycle done=0, busy=0, class_out=0, state IDLE. A following start with num_steps=1 and neuron 5 spiking → class_out=5, class_count=1.

Source files
------------

// File: rtl/spike_decoder_if.sv
// Spike decoder bus: output-layer spike vectors in, classification result out.
// The slave side is the decoder; the master side is whoever drives the
// inference window (the neuron array and the result register block).
interface spike_decoder_if #(
  parameter int NUM_OUTPUTS = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_WIDTH   = 4
);
  logic                   start;
  logic [CNT_WIDTH-1:0]   num_steps;
  logic                   spike_valid;
  logic [NUM_OUTPUTS-1:0] spike_in;
  logic                   spike_ready;
  logic                   busy;
  logic                   done;
  logic [IDX_WIDTH-1:0]   class_out;
  logic [CNT_WIDTH-1:0]   class_count;
  logic                   tie;

  modport master (
    output start, num_steps, spike_valid, spike_in,
    input  spike_ready, busy, done, class_out, class_count, tie
  );

  modport slave (
    input  start, num_steps, spike_valid, spike_in,
    output spike_ready, busy, done, class_out, class_count, tie
  );
endinterface

// File: rtl/spike_decoder.sv
// Spike decoder: counts output-neuron spikes over a programmed number of
// timesteps, then walks the counters one index per cycle to find the argmax.
// The lowest index wins ties; the tie flag reports that the winning count
// is shared by at least one other neuron.
module spike_decoder #(
  parameter int NUM_OUTPUTS = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_WIDTH   = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  spike_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_nextState;

  logic [CNT_WIDTH-1:0] r_cnt [NUM_OUTPUTS];
  logic [CNT_WIDTH-1:0] r_step;
  logic [CNT_WIDTH-1:0] r_numSteps;
  logic [CNT_WIDTH-1:0] r_best;
  logic [IDX_WIDTH-1:0] r_bestIdx;
  logic [IDX_WIDTH-1:0] r_scanIdx;
  logic                 r_tie;

  logic                 w_startAccept;
  logic                 w_xfer;
  logic                 w_lastStep;
  logic                 w_lastIdx;
  logic [CNT_WIDTH-1:0] w_scanCnt;

  // Start is only honoured while no window is running.
  assign w_startAccept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_xfer        = bus.spike_valid && (r_state == ACCUM);
  assign w_lastStep    = ((r_step + CNT_ONE) == r_numSteps);
  assign w_lastIdx     = (r_scanIdx == LAST_IDX);
  assign w_scanCnt     = r_cnt[r_scanIdx];

  // The result registers double as the running argmax during the scan.
  assign bus.class_out   = r_bestIdx;
  assign bus.class_count = r_best;
  assign bus.tie         = r_tie;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    w_nextState     = r_state;
    bus.spike_ready = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_startAccept) begin
          w_nextState = (bus.num_steps == '0) ? SCAN : ACCUM;
        end
      end
      ACCUM: begin
        bus.spike_ready = 1'b1;
        bus.busy        = 1'b1;
        if (w_xfer && w_lastStep) begin
          w_nextState = SCAN;
        end
      end
      SCAN: begin
        bus.busy = 1'b1;
        if (w_lastIdx) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (w_startAccept) begin
          w_nextState = (bus.num_steps == '0) ? SCAN : ACCUM;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Counters, step tracking and the sequential argmax scan.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        r_cnt[i] <= '0;
      end
      r_step     <= '0;
      r_numSteps <= '0;
      r_best     <= '0;
      r_bestIdx  <= '0;
      r_scanIdx  <= '0;
      r_tie      <= 1'b0;
    end else if (w_startAccept) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        r_cnt[i] <= '0;
      end
      r_step     <= '0;
      r_numSteps <= bus.num_steps;
      r_best     <= '0;
      r_bestIdx  <= '0;
      r_scanIdx  <= '0;
      r_tie      <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_xfer) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
              if (bus.spike_in[i] && (r_cnt[i] != '1)) begin
                r_cnt[i] <= r_cnt[i] + CNT_ONE;
              end
            end
            r_step <= r_step + CNT_ONE;
          end
        end
        SCAN: begin
          r_scanIdx <= w_lastIdx ? '0 : (r_scanIdx + IDX_WIDTH'(1));
          if (r_scanIdx == '0) begin
            r_best    <= w_scanCnt;
            r_bestIdx <= '0;
            r_tie     <= 1'b0;
          end else if (w_scanCnt > r_best) begin
            r_best    <= w_scanCnt;
            r_bestIdx <= r_scanIdx;
            r_tie     <= 1'b0;
          end else if (w_scanCnt == r_best) begin
            r_tie <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
